mmm_serial_engine: RTL and testbench
====================================

# mmm_serial_engine

Bit-serial radix-2 Montgomery modular multiplier that executes the multiply requests issued by the RSA exponentiation control FSM. It sits in the RSA datapath on the responder side of the control handshake. It accepts operands A, B and modulus M on a `start` pulse and returns R = A·B·2^-WIDTH mod M with a one-cycle `done` pulse. It serves every MAP, MMM and REMAP step of the exponentiation.

## Interface
Parameters:
- `WIDTH`, default 8: operand and modulus width in bits.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstb`  in  1  reset, synchronous and active-low.
- `ena`  in  1  global enable; when low, every register holds its value.
- `start`  in  1  request strobe; sampled only in IDLE or DONE.
- `a`  in  WIDTH  multiplicand; consumed LSB-first, captured at start.
- `b`  in  WIDTH  multiplier; captured at start.
- `m`  in  WIDTH  modulus; must be odd; captured at start.
- `busy`  out  1  high in ITER and SUB.
- `done`  out  1  one-cycle pulse, high only in DONE.
- `err`  out  1  high together with `done` when the captured `m` was even.
- `r`  out  WIDTH  result; valid from `done`, held until the next accepted start.

## Operation
- States: IDLE, ITER, SUB, DONE. Encoding is a 2-bit enum.
- **IDLE or DONE with start=1 and m[0]=1:**
  - capture a, b, m;
  - clear the accumulator acc (WIDTH+2 bits) and the bit counter;
  - go to ITER.
- **IDLE or DONE with start=1 and m[0]=0:**
  - set err=1 and r=0;
  - go directly to DONE; no iteration.
- **ITER, one bit per enabled cycle, i = counter:**
  - t = acc + a_i·b;
  - q = t[0];
  - acc ← (t + q·m) >> 1.
  - The counter increments each cycle. On the cycle with counter = WIDTH-1, go to SUB.
  - Width rule: t + q·m < 4m, so it fits in WIDTH+2 bits. The shift is logical.
- **SUB:** if acc ≥ m then r ← acc − m, else r ← acc[WIDTH-1:0]. Go to DONE.
- **DONE:**
  - done=1 for exactly one enabled cycle.
  - Next state is ITER if a valid start is present (back-to-back accepted), otherwise IDLE.
  - err clears on the next accepted start.
- `start` in ITER or SUB is ignored; no queuing.
- Preconditions are the caller's responsibility: a < m and b < m. Outside them the result is unspecified, but the engine must not hang.

## Timing
- Reset (rstb=0 at an edge): state=IDLE, acc=0, counter=0, r=0, busy=0, done=0, err=0. A mid-operation reset aborts with no done pulse.
- Latency with ena held high, where E0 is the edge sampling start:
  - done is high in the cycle after edge E0+WIDTH+1;
  - busy is high from E0 to E0+WIDTH+1.
- Each cycle with ena=0 stretches latency by one cycle. done stays high through ena-low cycles while in DONE.
- Even-modulus path: done (with err=1) is high in the cycle after E0.
- Counter wrap: width is $clog2(WIDTH). It never exceeds WIDTH-1 and is cleared on entry to ITER.

## Configuration
- `MMM_FINAL_SUB_EN` defined:
  - SUB state present; r < m guaranteed;
  - latency as stated in Timing.
- `MMM_FINAL_SUB_EN` undefined:
  - SUB state removed; ITER goes straight to DONE with r ← acc[WIDTH-1:0];
  - r lies in [0, 2m), and the caller must tolerate the redundant form;
  - done is one cycle earlier (after edge E0+WIDTH).

## Structure
- Shared package `rsa_pkg`: the `mmm_state_t` enum and the `MMM_ACC_EXTRA = 2` constant. The control FSM enum moves there as well.
- One sub-module, `mmm_iter_step`. It is combinational and maps (acc, a_i, b, m) to acc_next. It is instantiated once in ITER; the SUB compare/subtract stays in the top module.

## Test plan
All scenarios use WIDTH=8, m=13, with `MMM_FINAL_SUB_EN` defined unless noted.
- a=5, b=7 -> r=1 (35·2^-8 mod 13), done after edge E0+9, busy high for 9 edges.
- a=9 (2^8 mod 13), b=5 -> r=5; a=0, b=12 -> r=0; a=12, b=12 -> r=3.
- m=12 (even), start -> done with err=1 and r=0 in the cycle after E0. The next valid start clears err.
- Pulse start on the done cycle -> second operation accepted back-to-back with no IDLE cycle. A start during ITER is ignored and produces no extra done.
- ena toggled low for 3 cycles mid-ITER -> r is unchanged and done is delayed by exactly 3 cycles. rstb=0 mid-ITER -> IDLE, all outputs zero, no done.
- `MMM_FINAL_SUB_EN` undefined with 500 random a, b < 13 -> r ≡ reference mod 13, r < 26, done after edge E0+8.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA datapath types: Montgomery engine state, exponentiation control state,
// and the accumulator headroom constant.
package rsa_pkg;

  typedef enum logic [1:0] {
    MMM_IDLE = 2'd0,
    MMM_ITER = 2'd1,
    MMM_SUB  = 2'd2,
    MMM_DONE = 2'd3
  } mmm_state_t;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_MAP   = 3'd1,
    CTRL_SQR   = 3'd2,
    CTRL_MUL   = 3'd3,
    CTRL_REMAP = 3'd4,
    CTRL_DONE  = 3'd5
  } rsa_ctrl_state_t;

  // t + q*m < 4m, so two bits above the operand width are enough.
  localparam int MMM_ACC_EXTRA = 2;

endpackage

// File: rtl/mmm_serial_engine_if.sv
// Request/response bundle between the RSA control FSM (master) and the
// Montgomery multiplier (slave).
interface mmm_serial_engine_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] r;

  modport master (output start, a, b, m, input busy, done, err, r);
  modport slave  (input start, a, b, m, output busy, done, err, r);
endinterface

// File: rtl/mmm_serial_engine_iter_step.sv
// One radix-2 Montgomery step: acc_next = (acc + a_i*b + q*m) >> 1, q chosen so the
// sum is even.
module mmm_iter_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+MMM_ACC_EXTRA-1:0] i_acc,
  input  logic                           i_a_bit,
  input  logic [WIDTH-1:0]               i_b,
  input  logic [WIDTH-1:0]               i_m,
  output logic [WIDTH+MMM_ACC_EXTRA-1:0] o_acc_next
);
  localparam int ACC_W = WIDTH + MMM_ACC_EXTRA;

  logic [ACC_W-1:0] w_t;
  logic [ACC_W-1:0] w_u;

  assign w_t        = i_acc + (i_a_bit ? {{MMM_ACC_EXTRA{1'b0}}, i_b} : '0);
  assign w_u        = w_t + (w_t[0] ? {{MMM_ACC_EXTRA{1'b0}}, i_m} : '0);
  assign o_acc_next = w_u >> 1;
endmodule

// File: rtl/mmm_serial_engine.sv
// Bit-serial radix-2 Montgomery multiplier, R = A*B*2^-WIDTH mod M.
// Define MMM_FINAL_SUB_EN to include the final conditional subtraction (r < m).
module mmm_serial_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ena,
  mmm_serial_engine_if.slave  bus
);
  localparam int ACC_W = WIDTH + MMM_ACC_EXTRA;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mmm_state_t       r_state;
  mmm_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_res;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_last;

  assign w_accept    = bus.start && ((r_state == MMM_IDLE) || (r_state == MMM_DONE));
  assign w_start_ok  = w_accept && bus.m[0];
  assign w_start_bad = w_accept && !bus.m[0];
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  mmm_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_acc      (r_acc),
    .i_a_bit    (r_a[r_cnt]),
    .i_b        (r_b),
    .i_m        (r_m),
    .o_acc_next (w_acc_nxt)
  );

`ifdef MMM_FINAL_SUB_EN
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;
  // acc < 2m here, so the low WIDTH bits of acc - m are exact whenever acc >= m.
  assign w_sub = r_acc[WIDTH-1:0] - r_m;
  assign w_ge  = (r_acc >= {{MMM_ACC_EXTRA{1'b0}}, r_m});
`endif

  always_ff @(posedge clk) begin
    if (!rstb)     r_state <= MMM_IDLE;
    else if (ena)  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MMM_IDLE: begin
        if (w_start_ok)       w_state_nxt = MMM_ITER;
        else if (w_start_bad) w_state_nxt = MMM_DONE;
      end
      MMM_ITER: begin
`ifdef MMM_FINAL_SUB_EN
        if (w_last) w_state_nxt = MMM_SUB;
`else
        if (w_last) w_state_nxt = MMM_DONE;
`endif
      end
      MMM_SUB:  w_state_nxt = MMM_DONE;
      MMM_DONE: begin
        if (w_start_ok)       w_state_nxt = MMM_ITER;
        else if (w_start_bad) w_state_nxt = MMM_DONE;
        else                  w_state_nxt = MMM_IDLE;
      end
      default:  w_state_nxt = MMM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else if (ena) begin
      if (w_start_ok) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_m   <= bus.m;
        r_acc <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_start_bad) begin
        r_err <= 1'b1;
        r_res <= '0;
      end else if (r_state == MMM_ITER) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifndef MMM_FINAL_SUB_EN
        if (w_last) r_res <= w_acc_nxt[WIDTH-1:0];
`endif
      end
`ifdef MMM_FINAL_SUB_EN
      else if (r_state == MMM_SUB) begin
        r_res <= w_ge ? w_sub : r_acc[WIDTH-1:0];
      end
`endif
    end
  end

  assign bus.busy = (r_state == MMM_ITER) || (r_state == MMM_SUB);
  assign bus.done = (r_state == MMM_DONE);
  assign bus.err  = r_err;
  assign bus.r    = r_res;
endmodule

// File: tb/tb_mmm_serial_engine.sv
// Directed bench for mmm_serial_engine (WIDTH=8, m=13); expectations follow
// MMM_FINAL_SUB_EN when it is defined for the build.
module tb_mmm_serial_engine;
`ifdef MMM_FINAL_SUB_EN
  localparam int LAT    = 9;
  localparam int RBOUND = 13;
`else
  localparam int LAT    = 8;
  localparam int RBOUND = 26;
`endif

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic ena  = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;
  int   lat, bcnt, extra;

  mmm_serial_engine_if #(.WIDTH(8)) bus ();

  mmm_serial_engine #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one request; returns edges from E0 to done and busy-high cycle count.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] im,
                        input int stall_at, input int inject_at,
                        output int olat, output int obcnt);
    int k;
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.m = im; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0; obcnt = 0;
    while (!bus.done && k < 40) begin
      if (k == stall_at)      ena = 1'b0;
      if (k == stall_at + 3)  ena = 1'b1;
      if (k == inject_at) begin
        bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1;
      end
      if (k == inject_at + 1) bus.start = 1'b0;
      if (bus.busy) obcnt++;
      @(posedge clk);
      #1;
      k++;
    end
    ena = 1'b1;
    bus.start = 1'b0;
    olat = k;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.m = 8'd13;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err",  bus.err,  0);
    chk("rst_r",    bus.r,    0);
    rstb = 1'b1;

    run_op(8'd5, 8'd7, 8'd13, -10, -10, lat, bcnt);
    chk("5x7_r",    bus.r,   1);
    chk("5x7_lat",  lat,     LAT);
    chk("5x7_busy", bcnt,    LAT);
    chk("5x7_err",  bus.err, 0);
    @(posedge clk); #1;
    chk("done_pulse_once", bus.done, 0);

    run_op(8'd9, 8'd5, 8'd13, -10, -10, lat, bcnt);
    chk("9x5_r", bus.r, 5);
    run_op(8'd0, 8'd12, 8'd13, -10, -10, lat, bcnt);
    chk("0x12_r", bus.r, 0);
    run_op(8'd12, 8'd12, 8'd13, -10, -10, lat, bcnt);
    chk("12x12_r",   bus.r, 3);
    chk("12x12_lat", lat,   LAT);

    run_op(8'd5, 8'd7, 8'd12, -10, -10, lat, bcnt);
    chk("even_lat",  lat,     0);
    chk("even_err",  bus.err, 1);
    chk("even_r",    bus.r,   0);
    chk("even_busy", bcnt,    0);
    // Back-to-back: start pulsed during the done cycle of the even-m request.
    run_op(8'd9, 8'd5, 8'd13, -10, -10, lat, bcnt);
    chk("b2b_err_clr", bus.err, 0);
    chk("b2b_r",       bus.r,   5);
    chk("b2b_lat",     lat,     LAT);
    chk("b2b_busy",    bcnt,    LAT);
    run_op(8'd12, 8'd12, 8'd13, -10, -10, lat, bcnt);
    chk("b2b2_r",   bus.r, 3);
    chk("b2b2_lat", lat,   LAT);

    run_op(8'd5, 8'd7, 8'd13, -10, 3, lat, bcnt);
    chk("inject_r",   bus.r, 1);
    chk("inject_lat", lat,   LAT);
    count_done(15, extra);
    chk("inject_no_extra_done", extra, 0);

    run_op(8'd12, 8'd12, 8'd13, 2, -10, lat, bcnt);
    chk("ena_r",    bus.r, 3);
    chk("ena_lat",  lat,   LAT + 3);
    chk("ena_busy", bcnt,  LAT + 3);

    @(negedge clk);
    bus.a = 8'd5; bus.b = 8'd7; bus.m = 8'd13; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_err",  bus.err,  0);
    chk("midrst_r",    bus.r,    0);
    rstb = 1'b1;
    count_done(15, extra);
    chk("midrst_no_done", extra, 0);

    for (int i = 0; i < 500; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(12));
      rb = 8'($urandom_range(12));
      run_op(ra, rb, 8'd13, -10, -10, lat, bcnt);
      chk("rand_mod",   int'(bus.r) % 13, (int'(ra) * int'(rb) * 3) % 13);
      chk("rand_bound", (int'(bus.r) < RBOUND) ? 1 : 0, 1);
      chk("rand_lat",   lat, LAT);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
